// File: rtl/ga_rtl_pkg.sv
// Shared types and constants for the GA parent-selection datapath.
package ga_rtl_pkg;

    // Selection scheme requested with each draw.
    typedef logic [0:0] selection_t;
    localparam selection_t SEL_PROPORTIONATE = 1'b0;
    localparam selection_t SEL_RANK          = 1'b1;

    // Selection FSM encoding; exported on the debug port as well.
    typedef logic [2:0] sel_state_t;
    localparam sel_state_t ST_IDLE  = 3'd0;
    localparam sel_state_t ST_LOAD  = 3'd1;
    localparam sel_state_t ST_READY = 3'd2;
    localparam sel_state_t ST_DRAW  = 3'd3;
    localparam sel_state_t ST_SCAN  = 3'd4;
    localparam sel_state_t ST_OUT   = 3'd5;

    // Galois feedback taps for the 16-bit maximal-length LFSR.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/ga_lfsr.sv
// 16-bit Galois LFSR; advances one step per cycle while ADV is high.
module ga_lfsr
    import ga_rtl_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        ADV,
    output logic [15:0] VALUE
);

    // Shift right, folding the outgoing LSB back through the tap mask.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            VALUE <= SEED;
        end else if (ADV) begin
            VALUE <= {1'b0, VALUE[15:1]} ^ (VALUE[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/ga_selection_unit.sv
// Parent-selection stage: stores one population's fitness values, then
// serves roulette-wheel or rank selections, one index per request.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high (LOAD_VLD/LOAD_RDY, SEL_REQ/SEL_RDY, SEL_VLD/SEL_DST_RDY). SEL_VLD
// and SEL_IDX hold steady until accepted; LOAD_VLD has priority over SEL_REQ.
module ga_selection_unit
    import ga_rtl_pkg::*;
#(
    parameter int          POP_SIZE = 16,
    parameter int          FIT_W    = 16,
    parameter int          RND_W    = 16,
    parameter logic [15:0] SEED     = 16'hACE1,
    localparam int         IDX_W    = $clog2(POP_SIZE),
    localparam int         WT_W     = FIT_W + IDX_W + 1
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             LOAD_VLD,
    input  logic [FIT_W-1:0] LOAD_FIT,
    input  logic             LOAD_LAST,
    output logic             LOAD_RDY,
    output logic             POP_VALID,
    output logic [IDX_W:0]   POP_CNT,
    input  logic             SEL_REQ,
    input  logic             SEL_MODE,
    output logic             SEL_RDY,
    output logic             SEL_VLD,
    output logic [IDX_W-1:0] SEL_IDX,
    input  logic             SEL_DST_RDY,
    output sel_state_t       DBG_STATE,
    output logic [WT_W-1:0]  DBG_TOTAL
);

    localparam logic [IDX_W:0] POP_MAX = (IDX_W + 1)'(POP_SIZE);

    sel_state_t       state;
    logic [FIT_W-1:0] fit [POP_SIZE];
    logic [WT_W-1:0]  total;
    logic [WT_W-1:0]  thr;
    logic [WT_W-1:0]  acc;
    logic [IDX_W-1:0] scan_idx;
    selection_t       mode_q;
    logic [RND_W-1:0] rnd;

    logic             in_load;
    logic             load_fire;
    logic [IDX_W-1:0] wr_idx;
    logic [WT_W-1:0]  rank_tot;
    logic [WT_W-1:0]  w_tot;
    logic [WT_W-1:0]  thr_d;
    logic [IDX_W-1:0] zero_idx;
    logic [WT_W-1:0]  w_cur;
    logic [WT_W-1:0]  acc_next;
    logic             scan_last;

    ga_lfsr #(.SEED(SEED)) u_lfsr (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .ADV     (state == ST_DRAW),
        .VALUE   (rnd)
    );

    // Handshake readiness and the draw/scan arithmetic.
    always_comb begin
        in_load   = (state == ST_IDLE) || (state == ST_LOAD);
        LOAD_RDY  = (state == ST_READY) || (in_load && (POP_CNT != POP_MAX));
        load_fire = LOAD_VLD && LOAD_RDY;
        // A load arriving in READY restarts the population at index 0.
        wr_idx    = (state == ST_READY) ? '0 : POP_CNT[IDX_W-1:0];
        SEL_RDY   = (state == ST_READY) && !LOAD_VLD;
        SEL_VLD   = (state == ST_OUT);
        rank_tot  = (WT_W'(POP_CNT) * (WT_W'(POP_CNT) + WT_W'(1))) >> 1;
        w_tot     = (mode_q == SEL_RANK) ? rank_tot : total;
        // Scale the random word into [0, w_tot).
        thr_d     = WT_W'(({{WT_W{1'b0}}, rnd} * {{RND_W{1'b0}}, w_tot}) >> RND_W);
        zero_idx  = IDX_W'(({{(IDX_W + 1){1'b0}}, rnd} * {{RND_W{1'b0}}, POP_CNT}) >> RND_W);
        w_cur     = (mode_q == SEL_RANK) ? (WT_W'(scan_idx) + WT_W'(1))
                                         : WT_W'(fit[scan_idx]);
        acc_next  = acc + w_cur;
        scan_last = ({1'b0, scan_idx} == (POP_CNT - 1'b1));
        DBG_STATE = state;
        DBG_TOTAL = total;
    end

    // Fitness register file, written on every accepted load word.
    always_ff @(posedge CLK) begin
        if (load_fire) begin
            fit[wr_idx] <= LOAD_FIT;
        end
    end

    // Selection FSM with population bookkeeping.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= ST_IDLE;
            POP_CNT   <= '0;
            POP_VALID <= 1'b0;
            total     <= '0;
            thr       <= '0;
            acc       <= '0;
            scan_idx  <= '0;
            mode_q    <= SEL_PROPORTIONATE;
            SEL_IDX   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_LOAD: begin
                    if (load_fire) begin
                        POP_CNT <= POP_CNT + 1'b1;
                        total   <= total + WT_W'(LOAD_FIT);
                        if (LOAD_LAST) begin
                            state     <= ST_READY;
                            POP_VALID <= 1'b1;
                        end else begin
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_READY: begin
                    if (LOAD_VLD) begin
                        POP_CNT   <= (IDX_W + 1)'(1);
                        total     <= WT_W'(LOAD_FIT);
                        POP_VALID <= LOAD_LAST;
                        state     <= LOAD_LAST ? ST_READY : ST_LOAD;
                    end else if (SEL_REQ) begin
                        mode_q <= selection_t'(SEL_MODE);
                        state  <= ST_DRAW;
                    end
                end
                ST_DRAW: begin
                    acc      <= '0;
                    scan_idx <= '0;
                    thr      <= thr_d;
                    if (w_tot == '0) begin
                        SEL_IDX <= zero_idx;
                        state   <= ST_OUT;
                    end else begin
                        state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    acc <= acc_next;
                    if ((thr < acc_next) || scan_last) begin
                        SEL_IDX <= scan_idx;
                        state   <= ST_OUT;
                    end else begin
                        scan_idx <= scan_idx + 1'b1;
                    end
                end
                ST_OUT: begin
                    if (SEL_DST_RDY) begin
                        state <= ST_READY;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ga_selection_unit.sv
// Directed bench for ga_selection_unit with POP_SIZE=4 and SEED=16'h8000.
module tb_ga_selection_unit;
    import ga_rtl_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        load_vld;
    logic [15:0] load_fit;
    logic        load_last;
    logic        load_rdy;
    logic        pop_valid;
    logic [2:0]  pop_cnt;
    logic        sel_req;
    logic        sel_mode;
    logic        sel_rdy;
    logic        sel_vld;
    logic [1:0]  sel_idx;
    logic        sel_dst_rdy;
    sel_state_t  dbg_state;
    logic [18:0] dbg_total;

    int n_vec;
    int n_err;

    ga_selection_unit #(.POP_SIZE(4), .FIT_W(16), .RND_W(16), .SEED(16'h8000)) dut (
        .CLK         (clk),
        .RESET_N     (rst_n),
        .LOAD_VLD    (load_vld),
        .LOAD_FIT    (load_fit),
        .LOAD_LAST   (load_last),
        .LOAD_RDY    (load_rdy),
        .POP_VALID   (pop_valid),
        .POP_CNT     (pop_cnt),
        .SEL_REQ     (sel_req),
        .SEL_MODE    (sel_mode),
        .SEL_RDY     (sel_rdy),
        .SEL_VLD     (sel_vld),
        .SEL_IDX     (sel_idx),
        .SEL_DST_RDY (sel_dst_rdy),
        .DBG_STATE   (dbg_state),
        .DBG_TOTAL   (dbg_total)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] f0, f1, f2, f3;
        logic        mode;
        int          exp_tot;
        int          exp_idx;
        int          exp_lat;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        load_vld = 0; load_fit = 0; load_last = 0;
        sel_req = 0; sel_mode = 0; sel_dst_rdy = 0;
        rst_n = 0;
        tick(); tick();
        #3 rst_n = 1;
        tick();
    endtask

    task automatic load_pop(input logic [15:0] f0, f1, f2, f3);
        logic [15:0] f[4];
        f[0] = f0; f[1] = f1; f[2] = f2; f[3] = f3;
        for (int i = 0; i < 4; i++) begin
            load_vld  = 1;
            load_fit  = f[i];
            load_last = (i == 3);
            tick();
        end
        load_vld = 0; load_last = 0;
    endtask

    // Issue one request, measure cycles to SEL_VLD, optionally stall the output.
    task automatic do_select(input logic mode, input int exp_idx, input int exp_lat,
                             input int stall, input string tag);
        int n;
        sel_mode = mode;
        sel_req  = 1;
        #1;
        check({tag, " sel_rdy"}, int'(sel_rdy), 1);
        @(posedge clk);
        #1;
        sel_req = 0;
        n = 1;
        while (!sel_vld && n < 30) begin
            tick();
            n++;
        end
        check({tag, " latency"}, n, exp_lat);
        check({tag, " sel_idx"}, int'(sel_idx), exp_idx);
        for (int k = 0; k < stall; k++) begin
            sel_req = 1;
            #1;
            check({tag, " stall sel_vld"}, int'(sel_vld), 1);
            check({tag, " stall sel_idx"}, int'(sel_idx), exp_idx);
            check({tag, " stall sel_rdy"}, int'(sel_rdy), 0);
            tick();
        end
        sel_req = 0;
        sel_dst_rdy = 1;
        tick();
        sel_dst_rdy = 0;
        check({tag, " sel_vld drop"}, int'(sel_vld), 0);
        check({tag, " back to ready"}, int'(dbg_state), int'(ST_READY));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        // f0..f3, mode, total, idx, latency (seed 16'h8000 -> rnd 32768)
        vecs[0] = '{16'd10,  16'd0,  16'd30, 16'd60, 1'b0, 100, 3, 6};
        vecs[1] = '{16'd10,  16'd0,  16'd30, 16'd60, 1'b1, 100, 2, 5};
        vecs[2] = '{16'd0,   16'd0,  16'd0,  16'd0,  1'b0, 0,   2, 2};
        vecs[3] = '{16'd100, 16'd0,  16'd0,  16'd0,  1'b0, 100, 0, 3};
        vecs[4] = '{16'd0,   16'd0,  16'd0,  16'd5,  1'b0, 5,   3, 6};
        vecs[5] = '{16'd1,   16'd2,  16'd3,  16'd4,  1'b0, 10,  2, 5};
        vecs[6] = '{16'd0,   16'd0,  16'd0,  16'd0,  1'b1, 0,   2, 5};
        vecs[7] = '{16'd20,  16'd20, 16'd0,  16'd0,  1'b0, 40,  1, 4};

        do_reset();
        check("reset load_rdy", int'(load_rdy), 1);
        check("reset pop_valid", int'(pop_valid), 0);
        check("reset pop_cnt", int'(pop_cnt), 0);
        check("reset sel_rdy", int'(sel_rdy), 0);
        check("reset sel_vld", int'(sel_vld), 0);
        check("reset sel_idx", int'(sel_idx), 0);
        check("reset state", int'(dbg_state), int'(ST_IDLE));

        for (int v = 0; v < 8; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            do_reset();
            load_pop(vecs[v].f0, vecs[v].f1, vecs[v].f2, vecs[v].f3);
            check({tag, " pop_valid"}, int'(pop_valid), 1);
            check({tag, " pop_cnt"}, int'(pop_cnt), 4);
            check({tag, " total"}, int'(dbg_total), vecs[v].exp_tot);
            do_select(vecs[v].mode, vecs[v].exp_idx, vecs[v].exp_lat, 0, tag);
        end

        // Stalled output, then two more draws on the advancing LFSR
        // (rnd 16384 -> thr 25 -> idx 2; rnd 8192 -> thr 12 -> idx 2).
        do_reset();
        load_pop(16'd10, 16'd0, 16'd30, 16'd60);
        do_select(1'b0, 3, 6, 5, "stall");
        do_select(1'b0, 2, 5, 0, "lfsr2");
        do_select(1'b0, 2, 5, 0, "lfsr3");

        // Overflow: fifth word dropped, LAST on a refused cycle ignored.
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            load_vld = 1; load_fit = 16'(i); load_last = 0;
            tick();
        end
        check("ovf load_rdy", int'(load_rdy), 0);
        load_vld = 1; load_fit = 16'd99; load_last = 1;
        tick();
        load_vld = 0; load_last = 0;
        check("ovf pop_cnt", int'(pop_cnt), 4);
        check("ovf total", int'(dbg_total), 10);
        check("ovf pop_valid", int'(pop_valid), 0);
        check("ovf still refusing", int'(load_rdy), 0);

        // Reset mid-scan, then the first draw must reuse the seed.
        do_reset();
        load_pop(16'd10, 16'd0, 16'd30, 16'd60);
        sel_mode = 0; sel_req = 1;
        @(posedge clk);
        #1;
        sel_req = 0;
        tick(); tick();
        check("midscan state", int'(dbg_state), int'(ST_SCAN));
        rst_n = 0;
        #1;
        check("midscan rst load_rdy", int'(load_rdy), 1);
        check("midscan rst pop_valid", int'(pop_valid), 0);
        check("midscan rst pop_cnt", int'(pop_cnt), 0);
        check("midscan rst sel_rdy", int'(sel_rdy), 0);
        check("midscan rst sel_vld", int'(sel_vld), 0);
        check("midscan rst sel_idx", int'(sel_idx), 0);
        #3 rst_n = 1;
        tick();
        load_pop(16'd10, 16'd0, 16'd30, 16'd60);
        do_select(1'b0, 3, 6, 0, "reseed");

        // Load and request together in READY: load wins.
        sel_req = 1; load_vld = 1; load_fit = 16'd7; load_last = 0;
        #1;
        check("collide sel_rdy", int'(sel_rdy), 0);
        tick();
        sel_req = 0; load_vld = 0;
        check("collide pop_cnt", int'(pop_cnt), 1);
        check("collide pop_valid", int'(pop_valid), 0);
        check("collide total", int'(dbg_total), 7);
        check("collide state", int'(dbg_state), int'(ST_LOAD));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
